// File: rtl/debounce_pkg.sv
// Shared constants, repeat FSM state type and counter width helper for the
// push-button debouncer.
package debounce_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  localparam int unsigned DEF_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DEF_REPEAT_DELAY  = CLK_HZ / 2;
  localparam int unsigned DEF_REPEAT_PERIOD = CLK_HZ / 10;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, stable-count filter and
// auto-repeat FSM. Input is already polarity-corrected (1 = pressed).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic din,
  input  logic repeat_en,
  output logic pb_out,
  output logic press,
  output logic pb_release,
  output logic rpt,
  output logic press_next
);

  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W  = cnt_width(STABLE_CYCLES);
  localparam int unsigned RCNT_W = cnt_width(RMAX);

  logic              s1_q, s2_q;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  rpt_state_t        state_q, state_d;
  logic              press_q, rel_q, rpt_q, rpt_d;
  logic              rise, fall;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise    = s2_q;
      fall    = ~s2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    // Exit wins over a strobe that would fall on the same edge.
    if (fall || !repeat_en) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = DELAY;
            rcnt_d  = '0;
          end
        end
        DELAY: begin
          if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
            rpt_d   = 1'b1;
            state_d = REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        REPEAT: begin
          if (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1)) begin
            rpt_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      state_q <= IDLE;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      press_q <= rise;
      rel_q   <= fall;
      rpt_q   <= rpt_d;
    end
  end

  assign pb_out     = level_q;
  assign press      = press_q;
  assign pb_release = rel_q;
  assign rpt        = rpt_q;
  assign press_next = rise;

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer with per-channel polarity, press/release
// strobes, auto-repeat and a registered any-press flag.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned          N_CH          = 4,
  parameter int unsigned          STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned          REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_CH-1:0]      ACTIVE_LOW    = '0
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb,
  input  logic            repeat_en,
  output logic [N_CH-1:0] pb_out,
  output logic [N_CH-1:0] press,
  // Release strobe; 'release' itself is a reserved word.
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] rpt,
  output logic            any_press
);

  logic [N_CH-1:0] pb_logic;
  logic [N_CH-1:0] press_next;
  logic            any_press_q;

  assign pb_logic = pb ^ ACTIVE_LOW;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .din       (pb_logic[i]),
      .repeat_en (repeat_en),
      .pb_out    (pb_out[i]),
      .press     (press[i]),
      .pb_release(pb_release[i]),
      .rpt       (rpt[i]),
      .press_next(press_next[i])
    );
  end

  // Built from the pre-register press terms so it lines up with the press bits.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next;
    end
  end

  assign any_press = any_press_q;

endmodule
